instruction_loader: RTL and testbench

Upstream stage of `ARMProcessor`: receives a program as a byte stream over a valid/ready handshake, assembles bytes MSB-first into 32-bit instruction words, and drives the processor's instruction-write port (`write_ins`, `ins_address`, `ins`) with one write pulse per word. Holds the processor off via `cpu_hold` until a complete, valid program has been written.

---
 rtl/loader_pkg.sv | 17 +
 rtl/loader_word_assembler.sv | 35 +++
 rtl/instruction_loader.sv | 133 +++++++++++++
 tb/tb_instruction_loader.sv | 273 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/loader_pkg.sv
// rtl/loader_pkg.sv - shared constants and state encoding for instruction_loader
package loader_pkg;

  localparam int BYTES_PER_WORD = 4;
  localparam int BYTE_CNT_W     = 2;

  typedef logic [2:0] state_t;

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_COUNT = 3'd1;
  localparam logic [2:0] ST_BYTES = 3'd2;
  localparam logic [2:0] ST_WRITE = 3'd3;
  localparam logic [2:0] ST_CHECK = 3'd4;
  localparam logic [2:0] ST_DONE  = 3'd5;
  localparam logic [2:0] ST_ERR   = 3'd6;

endpackage

// File: rtl/loader_word_assembler.sv
// rtl/loader_word_assembler.sv - MSB-first byte-to-word shift register with byte counter
module loader_word_assembler
  import loader_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        clear,
  input  logic        shift_en,
  input  logic [7:0]  byte_in,
  output logic [31:0] word,
  output logic        word_full
);

  logic [31:0]           shift_q;
  logic [BYTE_CNT_W-1:0] byte_cnt;

  // word is the value including the byte being accepted now, so the top can
  // capture a complete word on the same edge that takes the 4th byte
  assign word      = {shift_q[23:0], byte_in};
  assign word_full = shift_en && (byte_cnt == BYTE_CNT_W'(BYTES_PER_WORD - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shift_q  <= '0;
      byte_cnt <= '0;
    end else if (clear) begin
      shift_q  <= '0;
      byte_cnt <= '0;
    end else if (shift_en) begin
      shift_q  <= word;
      byte_cnt <= byte_cnt + BYTE_CNT_W'(1);
    end
  end

endmodule

// File: rtl/instruction_loader.sv
// rtl/instruction_loader.sv - byte-stream program loader; LOADER_CHECKSUM_EN adds a trailing sum byte
module instruction_loader
  import loader_pkg::*;
#(
  parameter int ADDR_W = 5
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              byte_valid,
  input  logic [7:0]        byte_data,
  output logic              byte_ready,
  output logic              write_ins,
  output logic [ADDR_W-1:0] ins_address,
  output logic [31:0]       ins,
  output logic              busy,
  output logic              done,
  output logic              error,
  output logic              cpu_hold
);

  localparam int MAX_WORDS = 1 << ADDR_W;

  state_t            state;
  logic [ADDR_W:0]   count_r;
  logic [ADDR_W-1:0] addr;
  logic              xfer;
  logic              asm_clear;
  logic              asm_shift;
  logic [31:0]       asm_word;
  logic              asm_full;
  logic              count_bad;
  logic              last_word;

  assign byte_ready = (state == ST_COUNT) || (state == ST_BYTES) || (state == ST_CHECK);
  assign xfer       = byte_valid && byte_ready;
  assign write_ins  = (state == ST_WRITE);
  assign busy       = (state == ST_COUNT) || (state == ST_BYTES) ||
                      (state == ST_WRITE) || (state == ST_CHECK);
  assign done       = (state == ST_DONE);
  assign error      = (state == ST_ERR);
  assign cpu_hold   = (state != ST_DONE);

  assign count_bad  = (byte_data == 8'd0) || (int'(byte_data) > MAX_WORDS);
  assign last_word  = (({1'b0, addr} + (ADDR_W+1)'(1)) == count_r);
  assign asm_clear  = (state == ST_COUNT) && xfer;
  assign asm_shift  = (state == ST_BYTES) && xfer;

  loader_word_assembler u_asm (
    .clk       (clk),
    .rst_n     (rst_n),
    .clear     (asm_clear),
    .shift_en  (asm_shift),
    .byte_in   (byte_data),
    .word      (asm_word),
    .word_full (asm_full)
  );

`ifdef LOADER_CHECKSUM_EN
  logic [7:0] sum;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sum <= 8'd0;
    end else if (asm_clear) begin
      sum <= 8'd0;
    end else if (asm_shift) begin
      sum <= sum + byte_data;
    end
  end
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= ST_IDLE;
      count_r     <= '0;
      addr        <= '0;
      ins_address <= '0;
      ins         <= '0;
    end else begin
      case (state)
        ST_IDLE, ST_DONE, ST_ERR: begin
          if (start) begin
            state <= ST_COUNT;
            addr  <= '0;
          end
        end
        ST_COUNT: begin
          if (xfer) begin
            if (count_bad) begin
              state <= ST_ERR;
            end else begin
              count_r <= byte_data[ADDR_W:0];
              addr    <= '0;
              state   <= ST_BYTES;
            end
          end
        end
        ST_BYTES: begin
          // ins/ins_address are only touched here so they hold after the strobe
          if (asm_full) begin
            ins         <= asm_word;
            ins_address <= addr;
            state       <= ST_WRITE;
          end
        end
        ST_WRITE: begin
          addr <= addr + ADDR_W'(1);
          if (last_word) begin
`ifdef LOADER_CHECKSUM_EN
            state <= ST_CHECK;
`else
            state <= ST_DONE;
`endif
          end else begin
            state <= ST_BYTES;
          end
        end
        ST_CHECK: begin
`ifdef LOADER_CHECKSUM_EN
          if (xfer) begin
            state <= (byte_data == sum) ? ST_DONE : ST_ERR;
          end
`else
          state <= ST_ERR;
`endif
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_instruction_loader.sv
// tb/tb_instruction_loader.sv - directed self-checking bench for instruction_loader
module tb_instruction_loader;

  localparam int ADDR_W = 5;
  localparam int TMO    = 200;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              start = 1'b0;
  logic              byte_valid = 1'b0;
  logic [7:0]        byte_data = 8'd0;
  logic              byte_ready;
  logic              write_ins;
  logic [ADDR_W-1:0] ins_address;
  logic [31:0]       ins;
  logic              busy;
  logic              done;
  logic              error;
  logic              cpu_hold;

  int checks = 0;
  int errors = 0;

  logic [31:0] wr_data [0:127];
  logic [31:0] wr_addr [0:127];
  int          wr_count = 0;
  logic [7:0]  run_sum;
  logic [31:0] prog [0:31];
  int          base;

  instruction_loader #(.ADDR_W(ADDR_W)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .byte_valid  (byte_valid),
    .byte_data   (byte_data),
    .byte_ready  (byte_ready),
    .write_ins   (write_ins),
    .ins_address (ins_address),
    .ins         (ins),
    .busy        (busy),
    .done        (done),
    .error       (error),
    .cpu_hold    (cpu_hold)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (write_ins && wr_count < 128) begin
      wr_data[wr_count] = ins;
      wr_addr[wr_count] = 32'(ins_address);
      wr_count = wr_count + 1;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic pulse_start();
    @(negedge clk) start = 1'b1;
    @(negedge clk) start = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b);
    int t;
    t = 0;
    @(negedge clk);
    byte_valid = 1'b1;
    byte_data  = b;
    while (!byte_ready && t < TMO) begin
      @(negedge clk);
      t++;
    end
    chk("byte_accept_timeout", 32'(t < TMO), 32'd1);
    @(posedge clk);
    #1 byte_valid = 1'b0;
  endtask

  task automatic send_data(input logic [7:0] b);
    run_sum = run_sum + b;
    send_byte(b);
  endtask

  task automatic send_word(input logic [31:0] w);
    for (int k = 3; k >= 0; k--) send_data(w[8*k +: 8]);
  endtask

  task automatic send_sum();
`ifdef LOADER_CHECKSUM_EN
    send_byte(run_sum);
`endif
  endtask

  task automatic wait_not_busy();
    int t;
    t = 0;
    @(negedge clk);
    while (busy && t < TMO) begin
      @(negedge clk);
      t++;
    end
    chk("busy_timeout", 32'(t < TMO), 32'd1);
  endtask

  task automatic check_outputs_reset(input string tag);
    chk({tag, "_byte_ready"}, 32'(byte_ready), 32'd0);
    chk({tag, "_write_ins"}, 32'(write_ins), 32'd0);
    chk({tag, "_ins_address"}, 32'(ins_address), 32'd0);
    chk({tag, "_ins"}, ins, 32'd0);
    chk({tag, "_busy"}, 32'(busy), 32'd0);
    chk({tag, "_done"}, 32'(done), 32'd0);
    chk({tag, "_error"}, 32'(error), 32'd0);
    chk({tag, "_cpu_hold"}, 32'(cpu_hold), 32'd1);
  endtask

  task automatic check_end(input string tag, input logic exp_done);
    chk({tag, "_done"}, 32'(done), 32'(exp_done));
    chk({tag, "_error"}, 32'(error), 32'(!exp_done));
    chk({tag, "_cpu_hold"}, 32'(cpu_hold), 32'(!exp_done));
    chk({tag, "_busy"}, 32'(busy), 32'd0);
  endtask

  initial begin
    // reset state
    repeat (3) @(negedge clk);
    check_outputs_reset("reset");
    rst_n = 1'b1;
    @(negedge clk);
    check_outputs_reset("idle");

    // single word with write-strobe latency
    base = wr_count;
    pulse_start();
    run_sum = 8'd0;
    send_byte(8'd1);
    send_word(32'hF2800004);
    chk("w1_strobe", 32'(write_ins), 32'd1);
    chk("w1_ins", ins, 32'hF2800004);
    chk("w1_addr", 32'(ins_address), 32'd0);
    chk("w1_ready_in_write", 32'(byte_ready), 32'd0);
`ifndef LOADER_CHECKSUM_EN
    @(posedge clk);
    #1;
    chk("w1_done_latency", 32'(done), 32'd1);
    chk("w1_hold_latency", 32'(cpu_hold), 32'd0);
`endif
    send_sum();
    wait_not_busy();
    check_end("w1", 1'b1);
    chk("w1_count", 32'(wr_count - base), 32'd1);
    chk("w1_data", wr_data[base], 32'hF2800004);
    chk("w1_ins_hold", ins, 32'hF2800004);

    // two words with a 3-cycle stall mid-word
    base = wr_count;
    pulse_start();
    chk("w2_hold_after_start", 32'(cpu_hold), 32'd1);
    chk("w2_done_cleared", 32'(done), 32'd0);
    run_sum = 8'd0;
    send_byte(8'd2);
    send_data(8'hF2);
    send_data(8'h80);
    repeat (3) @(negedge clk);
    chk("w2_stall_no_write", 32'(wr_count - base), 32'd0);
    send_data(8'h10);
    send_data(8'h08);
    send_word(32'h0AFFFFFB);
    send_sum();
    wait_not_busy();
    check_end("w2", 1'b1);
    chk("w2_count", 32'(wr_count - base), 32'd2);
    chk("w2_addr0", wr_addr[base], 32'd0);
    chk("w2_data0", wr_data[base], 32'hF2801008);
    chk("w2_addr1", wr_addr[base+1], 32'd1);
    chk("w2_data1", wr_data[base+1], 32'h0AFFFFFB);

    // count 0 and count 33 are rejected
    base = wr_count;
    pulse_start();
    send_byte(8'd0);
    wait_not_busy();
    check_end("cnt0", 1'b0);
    pulse_start();
    send_byte(8'd33);
    wait_not_busy();
    check_end("cnt33", 1'b0);
    chk("bad_cnt_no_write", 32'(wr_count - base), 32'd0);

    // count 32: full memory
    for (int i = 0; i < 32; i++) prog[i] = 32'h01020304 * (i + 1) ^ 32'hA5000000;
    base = wr_count;
    pulse_start();
    run_sum = 8'd0;
    send_byte(8'd32);
    for (int i = 0; i < 32; i++) send_word(prog[i]);
    send_sum();
    wait_not_busy();
    check_end("cnt32", 1'b1);
    chk("cnt32_count", 32'(wr_count - base), 32'd32);
    for (int i = 0; i < 32; i++) begin
      chk($sformatf("cnt32_addr%0d", i), wr_addr[base+i], 32'(i));
      chk($sformatf("cnt32_data%0d", i), wr_data[base+i], prog[i]);
    end

`ifdef LOADER_CHECKSUM_EN
    // explicit checksum good/bad
    pulse_start();
    send_byte(8'd1);
    send_word(32'hF2800004);
    send_byte(8'h76);
    wait_not_busy();
    check_end("csum_good", 1'b1);
    pulse_start();
    send_byte(8'd1);
    send_word(32'hF2800004);
    send_byte(8'h77);
    wait_not_busy();
    check_end("csum_bad", 1'b0);
`endif

    // reset mid-load, then a clean reload from address 0
    base = wr_count;
    pulse_start();
    send_byte(8'd1);
    send_data(8'h12);
    send_data(8'h34);
    #2 rst_n = 1'b0;
    #1;
    check_outputs_reset("midrst");
    @(negedge clk);
    rst_n = 1'b1;
    chk("midrst_no_write", 32'(wr_count - base), 32'd0);
    pulse_start();
    run_sum = 8'd0;
    send_byte(8'd1);
    send_word(32'h12345678);
    send_sum();
    wait_not_busy();
    check_end("reload", 1'b1);
    chk("reload_count", 32'(wr_count - base), 32'd1);
    chk("reload_addr", wr_addr[base], 32'd0);
    chk("reload_data", wr_data[base], 32'h12345678);

    // start during BYTES is ignored
    base = wr_count;
    pulse_start();
    run_sum = 8'd0;
    send_byte(8'd1);
    send_data(8'hDE);
    send_data(8'hAD);
    pulse_start();
    chk("ign_start_busy", 32'(busy), 32'd1);
    chk("ign_start_ready", 32'(byte_ready), 32'd1);
    send_data(8'hBE);
    send_data(8'hEF);
    send_sum();
    wait_not_busy();
    check_end("ign_start", 1'b1);
    chk("ign_start_count", 32'(wr_count - base), 32'd1);
    chk("ign_start_data", wr_data[base], 32'hDEADBEEF);
    chk("ign_start_addr", wr_addr[base], 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
